// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt scheduler: cause codes, privilege
// encodings, scheduler states and the fixed interrupt priority ranking.
package irq_sched_pkg;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_SEI = 4'd9;
  localparam logic [3:0] CAUSE_SSI = 4'd1;
  localparam logic [3:0] CAUSE_STI = 4'd5;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BLANK = 2'd2,
    WFI   = 2'd3
  } irqstate_t;

  // Larger rank wins; rank 0 means the bit never raises an interrupt.
  function automatic logic [2:0] prio_rank(input logic [3:0] cause);
    case (cause)
      CAUSE_MEI: prio_rank = 3'd6;
      CAUSE_MSI: prio_rank = 3'd5;
      CAUSE_MTI: prio_rank = 3'd4;
      CAUSE_SEI: prio_rank = 3'd3;
      CAUSE_SSI: prio_rank = 3'd2;
      CAUSE_STI: prio_rank = 3'd1;
      default:   prio_rank = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/irq_sched_prio.sv
// Combinational eligibility filter and fixed-priority encoder; selects the
// most urgent enabled, pending and currently takeable interrupt.
module irq_prio
  import irq_sched_pkg::*;
#(
  parameter bit S_SUPPORTED = 1'b1
) (
  input  logic [11:0] pend,
  input  logic [11:0] deleg,
  input  logic [1:0]  mode,
  input  logic        status_mie,
  input  logic        status_sie,
  output logic        valid,
  output logic [3:0]  cause,
  output logic        to_s
);

  logic [11:0] m_level;
  logic [11:0] elig;
  logic        m_ok;
  logic        s_ok;
  logic [2:0]  best_rank;
  logic [2:0]  rank;

  assign m_level = S_SUPPORTED ? ~deleg : 12'hfff;
  assign m_ok    = (mode != M_MODE) | status_mie;
  // S-level interrupts are never taken while running in M mode.
  assign s_ok    = (mode == U_MODE) | ((mode == S_MODE) & status_sie);
  assign elig    = pend & ((m_level & {12{m_ok}}) | (~m_level & {12{s_ok}}));

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    best_rank = 3'd0;
    rank      = 3'd0;
    cause     = 4'd0;
    to_s      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rank = prio_rank(4'(i));
      if (elig[i] && (rank > best_rank)) begin
        best_rank = rank;
        cause     = 4'(i);
        to_s      = ~m_level[i];
      end
    end
    valid = (best_rank != 3'd0);
  end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: holds a stable request for the trap logic until it is
// acknowledged, and sequences WFI wake-up and the TW timeout.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter bit S_SUPPORTED      = 1'b1,
  parameter bit U_SUPPORTED      = 1'b1,
  parameter int WFI_TIMEOUT_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallW,
  input  logic [11:0] MIP_REGW,
  input  logic [11:0] MIE_REGW,
  input  logic [11:0] MIDELEG_REGW,
  input  logic [1:0]  PrivilegeModeW,
  input  logic        STATUS_MIE,
  input  logic        STATUS_SIE,
  input  logic        STATUS_TW,
  input  logic        TrapM,
  input  logic        mretM,
  input  logic        sretM,
  input  logic        wfiM,
  output logic        InterruptM,
  output logic [3:0]  IntCauseM,
  output logic        IntToSM,
  output logic        WFIWakeM,
  output logic        WFITimeoutM
);

  irqstate_t                   state_q, state_d;
  logic [3:0]                  cause_q, cause_d;
  logic                        tos_q, tos_d;
  logic [WFI_TIMEOUT_BITS-1:0] count_q, count_d;

  logic [11:0] pend;
  logic        sel_valid;
  logic [3:0]  sel_cause;
  logic        sel_to_s;
  logic        cnt_en;
  logic        timeout;
  logic        wake;

  assign pend = MIP_REGW & MIE_REGW;

  irq_prio #(.S_SUPPORTED(S_SUPPORTED)) u_prio (
    .pend       (pend),
    .deleg      (MIDELEG_REGW),
    .mode       (PrivilegeModeW),
    .status_mie (STATUS_MIE),
    .status_sie (STATUS_SIE),
    .valid      (sel_valid),
    .cause      (sel_cause),
    .to_s       (sel_to_s)
  );

  // Wake-up ignores global enables and delegation: any enabled pending bit ends WFI.
  assign cnt_en  = STATUS_TW & U_SUPPORTED & (PrivilegeModeW != M_MODE);
  assign timeout = (state_q == WFI) & cnt_en & (&count_q);
  assign wake    = (pend != 12'd0) | timeout;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tos_d   = tos_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = REQ;
          cause_d = sel_cause;
          tos_d   = sel_to_s;
        end else if (wfiM) begin
          state_d = WFI;
          count_d = '0;
        end else if (mretM | sretM) begin
          state_d = BLANK;
        end
      end
      REQ: begin
        if (TrapM) begin
          state_d = BLANK;
        end else if (!sel_valid) begin
          state_d = IDLE;
        end else begin
          cause_d = sel_cause;
          tos_d   = sel_to_s;
        end
      end
      BLANK: state_d = IDLE;
      WFI: begin
        if (TrapM) begin
          state_d = BLANK;
        end else if (wake) begin
          state_d = IDLE;
        end else if (cnt_en) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= 4'd0;
      tos_q   <= 1'b0;
      count_q <= '0;
    end else if (!StallW) begin
      state_q <= state_d;
      cause_q <= cause_d;
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  assign InterruptM  = (state_q == REQ);
  assign IntCauseM   = (state_q == REQ) ? cause_q : 4'd0;
  assign IntToSM     = (state_q == REQ) & tos_q;
  assign WFIWakeM    = (state_q == WFI) & wake;
  assign WFITimeoutM = timeout;

endmodule

// File: tb/tb_irq_sched.sv
// Directed self-checking bench for irq_sched: request/acknowledge, priority,
// withdrawal, re-selection, WFI wake/timeout and reset abort.
module tb_irq_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallW;
  logic [11:0] MIP_REGW, MIE_REGW, MIDELEG_REGW;
  logic [1:0]  PrivilegeModeW;
  logic        STATUS_MIE, STATUS_SIE, STATUS_TW;
  logic        TrapM, mretM, sretM, wfiM;
  logic        InterruptM;
  logic [3:0]  IntCauseM;
  logic        IntToSM, WFIWakeM, WFITimeoutM;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_sched #(.S_SUPPORTED(1'b1), .U_SUPPORTED(1'b1), .WFI_TIMEOUT_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallW         (StallW),
    .MIP_REGW       (MIP_REGW),
    .MIE_REGW       (MIE_REGW),
    .MIDELEG_REGW   (MIDELEG_REGW),
    .PrivilegeModeW (PrivilegeModeW),
    .STATUS_MIE     (STATUS_MIE),
    .STATUS_SIE     (STATUS_SIE),
    .STATUS_TW      (STATUS_TW),
    .TrapM          (TrapM),
    .mretM          (mretM),
    .sretM          (sretM),
    .wfiM           (wfiM),
    .InterruptM     (InterruptM),
    .IntCauseM      (IntCauseM),
    .IntToSM        (IntToSM),
    .WFIWakeM       (WFIWakeM),
    .WFITimeoutM    (WFITimeoutM)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallW = 0; MIP_REGW = 0; MIE_REGW = 0; MIDELEG_REGW = 0;
    PrivilegeModeW = 2'b11; STATUS_MIE = 0; STATUS_SIE = 0; STATUS_TW = 0;
    TrapM = 0; mretM = 0; sretM = 0; wfiM = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM, IntToSM, WFIWakeM, WFITimeoutM} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {InterruptM, IntCauseM, IntToSM, WFIWakeM, WFITimeoutM});
    end
    reset = 0;
    tick();
    n_checks++;
    if ({InterruptM, WFIWakeM, WFITimeoutM} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 000", {InterruptM, WFIWakeM, WFITimeoutM});
    end
  endtask

  // U mode, MTI: request next cycle, then TrapM gives exactly one blank cycle.
  task automatic test_request_ack();
    do_reset();
    PrivilegeModeW = 2'b00; MIP_REGW = 12'h080; MIE_REGW = 12'h080;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM, IntToSM} !== {1'b1, 4'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL mti_request: got int=%b cause=%0d tos=%b expected int=1 cause=7 tos=0",
               InterruptM, IntCauseM, IntToSM);
    end
    TrapM = 1;
    tick();
    TrapM = 0;
    n_checks++;
    if (InterruptM !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_after_trap: got %b expected 0", InterruptM);
    end
    tick();
    n_checks++;
    if (InterruptM !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_blank: got %b expected 0", InterruptM);
    end
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL rerequest_after_blank: got int=%b cause=%0d expected int=1 cause=7",
               InterruptM, IntCauseM);
    end
  endtask

  task automatic test_priority();
    do_reset();
    PrivilegeModeW = 2'b11; STATUS_MIE = 1; MIP_REGW = 12'h888; MIE_REGW = 12'h888;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM, IntToSM} !== {1'b1, 4'd11, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_mei: got int=%b cause=%0d tos=%b expected int=1 cause=11 tos=0",
               InterruptM, IntCauseM, IntToSM);
    end
    do_reset();
    PrivilegeModeW = 2'b11; STATUS_MIE = 1; STATUS_SIE = 1;
    MIP_REGW = 12'h200; MIE_REGW = 12'h200; MIDELEG_REGW = 12'h200;
    tick();
    tick();
    n_checks++;
    if (InterruptM !== 1'b0) begin
      n_fail++;
      $display("FAIL s_masked_in_m: got %b expected 0", InterruptM);
    end
    PrivilegeModeW = 2'b00;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM, IntToSM} !== {1'b1, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL sei_deleg_u: got int=%b cause=%0d tos=%b expected int=1 cause=9 tos=1",
               InterruptM, IntCauseM, IntToSM);
    end
  endtask

  task automatic test_reselect_withdraw();
    do_reset();
    PrivilegeModeW = 2'b00; MIP_REGW = 12'h080; MIE_REGW = 12'h088;
    tick();
    MIP_REGW = 12'h088;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL reselect_msi: got int=%b cause=%0d expected int=1 cause=3", InterruptM, IntCauseM);
    end
    MIP_REGW = 12'h000;
    tick();
    n_checks++;
    if (InterruptM !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: got %b expected 0", InterruptM);
    end
    // Withdrawal lands in IDLE, so a new pending bit is requested on the next edge.
    MIP_REGW = 12'h080;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL withdraw_to_idle: got int=%b cause=%0d expected int=1 cause=7", InterruptM, IntCauseM);
    end
    // TrapM together with withdrawal must still go through the blank cycle.
    MIP_REGW = 12'h000; TrapM = 1;
    tick();
    TrapM = 0; MIP_REGW = 12'h080;
    tick();
    n_checks++;
    if (InterruptM !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_beats_withdraw: got %b expected 0", InterruptM);
    end
  endtask

  task automatic run_timeout(input int stall_at, input int expected);
    int n;
    do_reset();
    PrivilegeModeW = 2'b01; STATUS_TW = 1; wfiM = 1;
    tick();
    wfiM = 0;
    n = 0;
    while (WFITimeoutM !== 1'b1 && n < 60) begin
      if (n == stall_at) StallW = 1;
      if (n == stall_at + 5) StallW = 0;
      tick();
      n++;
    end
    n_checks++;
    if (n !== expected || WFIWakeM !== 1'b1) begin
      n_fail++;
      $display("FAIL wfi_timeout: got cycles=%0d wake=%b expected cycles=%0d wake=1", n, WFIWakeM, expected);
    end
    tick();
    n_checks++;
    if ({WFITimeoutM, WFIWakeM, InterruptM} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_one_cycle: got %b expected 000", {WFITimeoutM, WFIWakeM, InterruptM});
    end
  endtask

  task automatic test_wfi_timeout();
    run_timeout(-10, 15);
    run_timeout(5, 20);
  endtask

  task automatic test_wfi_wake();
    do_reset();
    PrivilegeModeW = 2'b11; STATUS_MIE = 0; wfiM = 1;
    tick();
    wfiM = 0;
    tick();
    n_checks++;
    if (WFIWakeM !== 1'b0) begin
      n_fail++;
      $display("FAIL wfi_no_wake: got %b expected 0", WFIWakeM);
    end
    MIP_REGW = 12'h800; MIE_REGW = 12'h800;
    #1;
    n_checks++;
    if ({WFIWakeM, InterruptM} !== 2'b10) begin
      n_fail++;
      $display("FAIL wfi_wake: got wake=%b int=%b expected wake=1 int=0", WFIWakeM, InterruptM);
    end
    tick();
    tick();
    n_checks++;
    if ({WFIWakeM, InterruptM} !== 2'b00) begin
      n_fail++;
      $display("FAIL wake_masked_idle: got wake=%b int=%b expected 00", WFIWakeM, InterruptM);
    end
    // wfiM with an eligible interrupt is a NOP: straight to REQ.
    do_reset();
    PrivilegeModeW = 2'b00; MIP_REGW = 12'h020; MIE_REGW = 12'h020; wfiM = 1;
    tick();
    wfiM = 0;
    n_checks++;
    if ({InterruptM, IntCauseM, WFIWakeM} !== {1'b1, 4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL wfi_nop: got int=%b cause=%0d wake=%b expected int=1 cause=5 wake=0",
               InterruptM, IntCauseM, WFIWakeM);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    PrivilegeModeW = 2'b00; MIP_REGW = 12'h002; MIE_REGW = 12'h002;
    tick();
    reset = 1;
    tick();
    n_checks++;
    if ({InterruptM, IntCauseM, IntToSM} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_in_req: got int=%b cause=%0d tos=%b expected all 0", InterruptM, IntCauseM, IntToSM);
    end
    reset = 0; MIP_REGW = 0;
    PrivilegeModeW = 2'b11; wfiM = 1;
    tick();
    wfiM = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    MIP_REGW = 12'h800; MIE_REGW = 12'h800;
    #1;
    n_checks++;
    if ({WFIWakeM, WFITimeoutM, InterruptM} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_in_wfi: got %b expected 000", {WFIWakeM, WFITimeoutM, InterruptM});
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_request_ack();
    test_priority();
    test_reselect_withdraw();
    test_wfi_timeout();
    test_wfi_wake();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
